// File: rtl/sine_dac_pkg.sv
// Shared constants, FSM state type and sample-to-DAC conversion.
// Define SINE_DAC_ROUND_EN to round (with saturation) instead of truncating.
package sine_dac_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int SUM_BITS   = 13;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    function automatic logic [DATA_BITS-1:0] to_data12(
        input logic [SUM_BITS-1:0] sum
    );
`ifdef SINE_DAC_ROUND_EN
        logic [SUM_BITS:0] r;
        r = {1'b0, sum} + (SUM_BITS+1)'(1);
        // Only 13'h1FFF carries out; its rounded value would need 13 bits
        if (r[SUM_BITS]) return '1;
        return r[SUM_BITS-1:1];
`else
        return DATA_BITS'(sum >> 1);
`endif
    endfunction

endpackage

// File: rtl/sine_dac_clkdiv.sv
// SCLK phase counter: emits rise/fall strobes every CLK_DIV cycles while en.
// Held cleared whenever en is low so each frame starts on a fresh low phase.
module sine_dac_clkdiv #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;
    logic       phase;
    logic       wrap;

    assign wrap = en && (cnt == LAST);
    assign rise = wrap && !phase;
    assign fall = wrap && phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/sine_dac_serializer.sv
// Serializes 13-bit sine-summer samples into 16-bit {cmd, data12} DAC frames.
// Build option SINE_DAC_ROUND_EN (see sine_dac_pkg) selects rounding.
module sine_dac_serializer
    import sine_dac_pkg::*;
#(
    parameter int         CLK_DIV = 2,
    parameter logic [3:0] DAC_CMD = 4'b0011
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SUM_BITS-1:0] sum_in,
    input  logic                sample_en,
    input  logic                ovr_clr,
    output logic                dac_csn,
    output logic                dac_sclk,
    output logic                dac_sdo,
    output logic                busy,
    output logic                overrun
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    state_t                state;
    state_t                state_nx;
    logic [FRAME_BITS-1:0] shreg;
    logic [3:0]            bit_cnt;
    logic [7:0]            hold_cnt;
    logic                  sclk_q;
    logic                  ovr_q;
    logic                  shift_en;
    logic                  rise;
    logic                  fall;
    logic                  accept;
    logic                  ovr_set;

    assign shift_en = (state == SHIFT);
    assign ovr_set  = sample_en && (state != IDLE);

    sine_dac_clkdiv #(
        .CLK_DIV(CLK_DIV)
    ) u_clkdiv (
        .clk (clk),
        .rst (rst),
        .en  (shift_en),
        .rise(rise),
        .fall(fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (sample_en) begin
                    accept   = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (fall && (bit_cnt == 4'd15)) state_nx = HOLD;
            end
            HOLD: begin
                if (hold_cnt == LAST) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Zero fill means sdo is already 0 once the last bit has shifted out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            hold_cnt <= '0;
            sclk_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            if (accept) begin
                shreg   <= {DAC_CMD, to_data12(sum_in)};
                bit_cnt <= '0;
            end else if (fall) begin
                shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (rise)      sclk_q <= 1'b1;
            else if (fall) sclk_q <= 1'b0;
            if (state == HOLD && hold_cnt != LAST) hold_cnt <= hold_cnt + 8'd1;
            else                                   hold_cnt <= '0;
            ovr_q <= ovr_set | (ovr_q & ~ovr_clr);
        end
    end

    assign dac_csn  = ~shift_en;
    assign dac_sclk = sclk_q;
    assign dac_sdo  = shreg[FRAME_BITS-1];
    assign busy     = (state != IDLE);
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_sine_dac_serializer.sv
// Directed bench: CLK_DIV=2 instance for framing/overrun/reset/back-to-back,
// CLK_DIV=1 instance for fast timing.
module tb_sine_dac_serializer;

`ifdef SINE_DAC_ROUND_EN
    localparam logic [15:0] E0003 = 16'h3002;
    localparam logic [15:0] E1235 = 16'h391B;
`else
    localparam logic [15:0] E0003 = 16'h3001;
    localparam logic [15:0] E1235 = 16'h391A;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] sum_in = '0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic        ovr_clr = 1'b0;
    logic        csn_a, sclk_a, sdo_a, busy_a, ovr_a;
    logic        csn_b, sclk_b, sdo_b, busy_b, ovr_b;

    int          n_run = 0;
    int          n_fail = 0;
    int          busy_n, rise_n, gap, sdo_bad, first_rise, last_rise;
    logic [31:0] bits;

    always #5 clk = ~clk;

    sine_dac_serializer #(.CLK_DIV(2)) u_dut_a (
        .clk(clk), .rst(rst), .sum_in(sum_in), .sample_en(en_a),
        .ovr_clr(ovr_clr), .dac_csn(csn_a), .dac_sclk(sclk_a),
        .dac_sdo(sdo_a), .busy(busy_a), .overrun(ovr_a)
    );

    sine_dac_serializer #(.CLK_DIV(1)) u_dut_b (
        .clk(clk), .rst(rst), .sum_in(sum_in), .sample_en(en_b),
        .ovr_clr(ovr_clr), .dac_csn(csn_b), .dac_sclk(sclk_b),
        .dac_sdo(sdo_b), .busy(busy_b), .overrun(ovr_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic sel);
        if (sel) en_b = 1'b1;
        else     en_a = 1'b1;
    endtask

    // Strobe v at i=0, then watch ncyc cycles sampled on the falling edge
    task automatic run(input logic sel, input int ncyc, input logic [12:0] v,
                       input int inj_at, input logic inj_clr,
                       input logic b2b, input logic [12:0] v2);
        logic pcsn, psclk, psdo, pbusy, seen, done2, cs, sc, sd, bz;
        int   gcnt;
        pcsn = 1'b1; psclk = 1'b0; psdo = 1'b0; pbusy = 1'b0;
        seen = 1'b0; done2 = 1'b0; gcnt = 0;
        busy_n = 0; rise_n = 0; gap = 0; sdo_bad = 0;
        first_rise = 0; last_rise = 0; bits = '0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            cs = sel ? csn_b  : csn_a;
            sc = sel ? sclk_b : sclk_a;
            sd = sel ? sdo_b  : sdo_a;
            bz = sel ? busy_b : busy_a;
            if (bz) busy_n++;
            if (sc && !psclk) begin
                if (rise_n == 0) first_rise = i;
                last_rise = i;
                rise_n++;
                bits = {bits[30:0], sd};
            end
            if (sd != psdo && !(psclk && !sc) && !(pcsn && !cs)) sdo_bad++;
            if (!cs) begin
                if (seen && gcnt > 0) gap = gcnt;
                seen = 1'b1;
                gcnt = 0;
            end else if (seen) begin
                gcnt++;
            end
            en_a = 1'b0;
            en_b = 1'b0;
            ovr_clr = 1'b0;
            if (i == 0) begin
                sum_in = v;
                strobe(sel);
            end
            if (i == inj_at) begin
                sum_in = 13'h0555;
                strobe(sel);
                ovr_clr = inj_clr;
            end
            if (b2b && !done2 && pbusy && !bz) begin
                sum_in = v2;
                strobe(sel);
                done2 = 1'b1;
            end
            pcsn = cs; psclk = sc; psdo = sd; pbusy = bz;
        end
        en_a = 1'b0;
        en_b = 1'b0;
        ovr_clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_csn", 32'(csn_a), 32'd1);
        chk("rst_sclk", 32'(sclk_a), 32'd0);
        chk("rst_sdo", 32'(sdo_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ovr", 32'(ovr_a), 32'd0);
        chk("rst_csn_b", 32'(csn_b), 32'd1);
        rst = 1'b0;

        run(1'b0, 80, 13'h1FFF, -1, 1'b0, 1'b0, '0);
        chk("full_bits", bits, 32'h3FFF);
        chk("full_rises", rise_n, 16);
        chk("full_busy", busy_n, 66);
        chk("full_span", last_rise - first_rise, 60);
        chk("full_sdo_edge", sdo_bad, 0);
        chk("full_ovr", 32'(ovr_a), 32'd0);

        run(1'b0, 80, 13'h0003, -1, 1'b0, 1'b0, '0);
        chk("data_0003", bits, 32'(E0003));
        run(1'b0, 80, 13'h1235, -1, 1'b0, 1'b0, '0);
        chk("data_1235", bits, 32'(E1235));
        run(1'b0, 80, 13'h0AAA, -1, 1'b0, 1'b0, '0);
        chk("data_0aaa", bits, 32'h3555);

        run(1'b0, 80, 13'h0AAA, 10, 1'b0, 1'b0, '0);
        chk("ovr_bits", bits, 32'h3555);
        chk("ovr_busy", busy_n, 66);
        chk("ovr_set", 32'(ovr_a), 32'd1);

        run(1'b0, 80, 13'h0003, 10, 1'b1, 1'b0, '0);
        chk("ovr_setclr", 32'(ovr_a), 32'd1);
        chk("ovr_setclr_bits", bits, 32'(E0003));
        @(negedge clk);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_clr", 32'(ovr_a), 32'd0);

        @(negedge clk);
        sum_in = 13'h1FFF;
        en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        repeat (9) @(negedge clk);
        en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        repeat (22) @(negedge clk);
        chk("mid_busy", 32'(busy_a), 32'd1);
        chk("mid_ovr", 32'(ovr_a), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_csn", 32'(csn_a), 32'd1);
        chk("mid_rst_sclk", 32'(sclk_a), 32'd0);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_sdo", 32'(sdo_a), 32'd0);
        chk("mid_rst_ovr", 32'(ovr_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_resume", 32'(busy_a), 32'd0);
        run(1'b0, 80, 13'h1235, -1, 1'b0, 1'b0, '0);
        chk("post_rst_bits", bits, 32'(E1235));
        chk("post_rst_busy", busy_n, 66);

        run(1'b0, 160, 13'h1FFF, -1, 1'b0, 1'b1, 13'h0003);
        chk("b2b_first", 32'(bits[31:16]), 32'h3FFF);
        chk("b2b_second", 32'(bits[15:0]), 32'(E0003));
        chk("b2b_gap", gap, 3);
        chk("b2b_rises", rise_n, 32);
        chk("b2b_busy", busy_n, 132);
        chk("b2b_ovr", 32'(ovr_a), 32'd0);

        run(1'b1, 45, 13'h0AAA, -1, 1'b0, 1'b0, '0);
        chk("div1_bits", bits, 32'h3555);
        chk("div1_rises", rise_n, 16);
        chk("div1_busy", busy_n, 33);
        chk("div1_span", last_rise - first_rise, 30);
        chk("div1_sdo_edge", sdo_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/sine_dac_serializer.md
SINE_DAC_SERIALIZER -- requirements
Module: sine_dac_serializer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCLK half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter DAC_CMD, default 4'b0011: command nibble prepended to each frame.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port sum_in  input  13: unsigned sample from the two-tone sine summer.
REQ-006 SHALL have port sample_en  input  1: one-cycle strobe; sum_in is valid in that cycle.
REQ-007 SHALL have port ovr_clr  input  1: clears the sticky overrun flag.
REQ-008 SHALL have port dac_csn  output  1: active-low frame select.
REQ-009 SHALL have port dac_sclk  output  1: serial clock; idles low.
REQ-010 SHALL have port dac_sdo  output  1: serial data, MSB first.
REQ-011 SHALL have port busy  output  1: frame in progress.
REQ-012 SHALL have port overrun  output  1: sticky flag; a strobe was dropped.

Function
REQ-013 SHALL use FSM states IDLE, SHIFT, HOLD; transitions IDLE->SHIFT on accepted strobe, SHIFT->HOLD after bit 0, HOLD->IDLE after CLK_DIV cycles.
REQ-014 SHALL accept sample_en only in IDLE; the next edge sets csn=0, busy=1, loads a 16-bit frame {DAC_CMD, data12} and drives sdo=frame[15].
REQ-015 SHALL form data12 = sum_in[12:1] (truncation) when the rounding feature is compiled out.
REQ-016 SHALL hold sclk low for CLK_DIV cycles, then high for CLK_DIV cycles, per bit; sdo changes only on the edge where sclk falls.
REQ-017 SHALL, after the high phase of bit 0, drive sclk=0, csn=1, sdo=0 and enter HOLD.
REQ-018 SHALL hold busy high for exactly 32*CLK_DIV + CLK_DIV cycles per frame (66 cycles at CLK_DIV=2).
REQ-019 SHALL, on sample_en while busy, drop the sample, leave the frame in progress untouched and set overrun.
REQ-020 SHALL clear overrun on ovr_clr; simultaneous set and clear SHALL leave overrun set.
REQ-021 SHALL accept a strobe in the first IDLE cycle after HOLD (back-to-back frames).

Reset
REQ-022 SHALL on rst, including mid-frame, immediately force state=IDLE, csn=1, sclk=0, sdo=0, busy=0, overrun=0, counters=0; no partial frame resumes.

Configuration
REQ-023 SHALL, with SINE_DAC_ROUND_EN defined, form data12 = (sum_in+1)>>1 saturated to 12'hFFF; without it, truncation per REQ-015.

Structure
REQ-024 SHALL place FRAME_BITS=16, DATA_BITS=12, SUM_BITS=13 and the state enum in package sine_dac_pkg.
REQ-025 SHALL implement SCLK phase timing in sub-module sine_dac_clkdiv (phase counter with rise/fall strobes, cleared outside SHIFT).

Verification
REQ-026 SHALL cover: CLK_DIV=2, sum_in=13'h1FFF strobe -> 16 sclk pulses, sdo stream 16'h3FFF, busy 66 cycles.
REQ-027 SHALL cover: sum_in=13'h0003 -> data12 0x001 without SINE_DAC_ROUND_EN, 0x002 with it; 13'h1FFF with it -> 0xFFF (saturated).
REQ-028 SHALL cover: strobe at cycle 10 of a frame -> frame unchanged, overrun=1; ovr_clr with simultaneous strobe while busy -> overrun stays 1.
REQ-029 SHALL cover: rst asserted at bit 7 -> csn=1, sclk=0, busy=0 same cycle; next strobe -> full clean frame.
REQ-030 SHALL cover: strobe in first IDLE cycle after HOLD -> accepted, no overrun, csn high exactly CLK_DIV+1 cycles between frames.
REQ-031 SHALL cover: CLK_DIV=1 -> sclk period 2 cycles, busy 33 cycles.
